// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the rock-paper-scissors round controller.
//   move_t    : 2-bit player move code (ROCK, PAPER, SCISSORS, ILLEGAL)
//   result_t  : 2-bit round verdict (TIE, P1_WIN, P2_WIN)
//   pw_t      : 2-bit match winner code for the finish logic (NONE, DRAW, P1, P2)
//   state_t   : round sequencer states
package game_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    ILLEGAL  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    TIE    = 2'b00,
    P1_WIN = 2'b10,
    P2_WIN = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    DRAW = 2'b01,
    P1   = 2'b10,
    P2   = 2'b11
  } pw_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    JUDGE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rps_judge.sv
// rps_judge: combinational verdict for one rock-paper-scissors round.
//   move_a  in  2  first player's move (game_pkg::move_t encoding)
//   move_b  in  2  second player's move
//   outcome out 2  TIE, P1_WIN (move_a wins) or P2_WIN (move_b wins)
// An illegal move forfeits the round to the opponent; two illegal moves tie.
module rps_judge
  import game_pkg::*;
(
  input  logic [1:0] move_a,
  input  logic [1:0] move_b,
  output logic [1:0] outcome
);

  always_comb begin
    // NOTE: default first, so every path assigns outcome and no latch is inferred.
    outcome = TIE;
    if (move_a == ILLEGAL && move_b == ILLEGAL) begin
      outcome = TIE;
    end else if (move_a == ILLEGAL) begin
      outcome = P2_WIN;
    end else if (move_b == ILLEGAL) begin
      outcome = P1_WIN;
    end else if (move_a == move_b) begin
      outcome = TIE;
    end else begin
      case ({move_a, move_b})
        {PAPER, ROCK}, {SCISSORS, PAPER}, {ROCK, SCISSORS}: outcome = P1_WIN;
        default:                                             outcome = P2_WIN;
      endcase
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: two-player rock-paper-scissors match sequencer.
// Collects one move per player per round (valid/ready), judges the round,
// keeps round/win/lose counters from player 1's view and detects match end.
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               begin a new match (sampled only in IDLE or DONE)
//   p1_valid/p1_move    player 1 move offer; p1_ready accepts it
//   p2_valid/p2_move    player 2 move offer; p2_ready accepts it
//   busy                high while a match is in progress (WAIT/JUDGE/CHECK)
//   round, win, lose    4-bit counters
//   result_valid        one-cycle pulse after each judged round
//   result              last verdict (00 tie, 10 p1, 11 p2), held
//   fin, printwinner    match finished flag and winner code (00/10/11/01)
// Optional build macro TIE_REPLAY_EN: tied rounds are replayed and not counted,
// and the match-end check is skipped after a tie.
module game_round_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p2_ready,
  output logic       busy,
  output logic [3:0] round,
  output logic [3:0] win,
  output logic [3:0] lose,
  output logic       result_valid,
  output logic [1:0] result,
  output logic       fin,
  output logic [1:0] printwinner
);

  import game_pkg::*;

  localparam logic [3:0] WIN_T = 4'(WIN_TARGET);
  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  state_t     state;
  logic [1:0] p1_lat;
  logic [1:0] p2_lat;
  logic       p1_got;
  logic       p2_got;
  logic [1:0] verdict;

  rps_judge u_judge (
    .move_a  (p1_lat),
    .move_b  (p2_lat),
    .outcome (verdict)
  );

  // NOTE: every register, including the latched moves, is reset so a reset
  // mid-round leaves nothing behind for the next match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      p1_lat       <= ROCK;
      p2_lat       <= ROCK;
      p1_got       <= 1'b0;
      p2_got       <= 1'b0;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      busy         <= 1'b0;
      round        <= 4'd0;
      win          <= 4'd0;
      lose         <= 4'd0;
      result_valid <= 1'b0;
      result       <= TIE;
      fin          <= 1'b0;
      printwinner  <= NONE;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge register values regardless of statement order.
      result_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            round       <= 4'd0;
            win         <= 4'd0;
            lose        <= 4'd0;
            result      <= TIE;
            printwinner <= NONE;
            fin         <= 1'b0;
            busy        <= 1'b1;
            p1_ready    <= 1'b1;
            p2_ready    <= 1'b1;
            state       <= WAIT;
          end
        end

        WAIT: begin
          if (p1_valid && p1_ready) begin
            p1_lat   <= p1_move;
            p1_got   <= 1'b1;
            p1_ready <= 1'b0;
          end
          if (p2_valid && p2_ready) begin
            p2_lat   <= p2_move;
            p2_got   <= 1'b1;
            p2_ready <= 1'b0;
          end
          // Transition on the edge after the second latch: the judge then sees
          // stable registered moves for a whole cycle.
          if (p1_got && p2_got) begin
            state <= JUDGE;
          end
        end

        JUDGE: begin
          result       <= verdict;
          result_valid <= 1'b1;
          p1_got       <= 1'b0;
          p2_got       <= 1'b0;
          p1_lat       <= ROCK;
          p2_lat       <= ROCK;
          if (verdict == P1_WIN) win  <= win + 4'd1;
          if (verdict == P2_WIN) lose <= lose + 4'd1;
`ifdef TIE_REPLAY_EN
          if (verdict == TIE) begin
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
            state    <= WAIT;
          end else begin
            round <= round + 4'd1;
            state <= CHECK;
          end
`else
          round <= round + 4'd1;
          state <= CHECK;
`endif
        end

        CHECK: begin
          if (win == WIN_T || lose == WIN_T || round == MAX_R) begin
            state <= DONE;
            fin   <= 1'b1;
            busy  <= 1'b0;
            if (win == WIN_T)       printwinner <= P1;
            else if (lose == WIN_T) printwinner <= P2;
            else if (win > lose)    printwinner <= P1;
            else if (lose > win)    printwinner <= P2;
            else                    printwinner <= DRAW;
          end else begin
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
            state    <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed bench for game_round_ctrl (WIN_TARGET=3,
// MAX_ROUNDS=5) with a match-level reference model and a per-cycle comparer
// that runs whenever the controller is idle between handshakes.
module tb_game_round_ctrl;

  import game_pkg::*;

  localparam int WT = 3;
  localparam int MR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic       p1_ready;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move = 2'b00;
  logic       p2_ready;
  logic       busy;
  logic [3:0] round;
  logic [3:0] win;
  logic [3:0] lose;
  logic       result_valid;
  logic [1:0] result;
  logic       fin;
  logic [1:0] printwinner;

  game_round_ctrl #(.WIN_TARGET(WT), .MAX_ROUNDS(MR)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_valid     (p1_valid),
    .p1_move      (p1_move),
    .p1_ready     (p1_ready),
    .p2_valid     (p2_valid),
    .p2_move      (p2_move),
    .p2_ready     (p2_ready),
    .busy         (busy),
    .round        (round),
    .win          (win),
    .lose         (lose),
    .result_valid (result_valid),
    .result       (result),
    .fin          (fin),
    .printwinner  (printwinner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- match-level reference model ----------------
  int m_round, m_win, m_lose, m_result, m_pw;
  bit m_fin, m_busy;
  bit cmp_en = 1'b0;

  // 0 tie, 2 p1 wins, 3 p2 wins; moves are 0 rock, 1 paper, 2 scissors, 3 illegal.
  // Each legal move beats the one numbered one below it, modulo 3.
  function automatic int judge(input int a, input int b);
    if (a == 3 && b == 3) return 0;
    if (a == 3) return 3;
    if (b == 3) return 2;
    if (a == b) return 0;
    return (((a - b + 3) % 3) == 1) ? 2 : 3;
  endfunction

  task automatic model_clear(input bit in_match);
    m_round = 0; m_win = 0; m_lose = 0; m_result = 0; m_pw = 0;
    m_fin = 1'b0; m_busy = in_match;
  endtask

  task automatic model_round(input int a, input int b);
    m_result = judge(a, b);
`ifdef TIE_REPLAY_EN
    if (m_result == 0) return;
`endif
    m_round++;
    if (m_result == 2) m_win++;
    if (m_result == 3) m_lose++;
    if (m_win == WT) begin
      m_fin = 1'b1; m_pw = 2;
    end else if (m_lose == WT) begin
      m_fin = 1'b1; m_pw = 3;
    end else if (m_round == MR) begin
      m_fin = 1'b1;
      m_pw  = (m_win > m_lose) ? 2 : ((m_lose > m_win) ? 3 : 1);
    end
    if (m_fin) m_busy = 1'b0;
  endtask

  // Per-cycle comparer while the controller is settled (no handshake in flight).
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("round",        round,        m_round);
      check("win",          win,          m_win);
      check("lose",         lose,         m_lose);
      check("result",       result,       m_result);
      check("fin",          fin,          m_fin);
      check("printwinner",  printwinner,  m_pw);
      check("busy",         busy,         m_busy);
      check("p1_ready",     p1_ready,     m_busy);
      check("p2_ready",     p2_ready,     m_busy);
      check("result_valid", result_valid, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    cmp_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_counters", {round, win, lose, result, printwinner}, 0);
    check("rst_flags", {fin, busy, result_valid, p1_ready, p2_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear(1'b0);
    cmp_en = 1'b1;
  endtask

  task automatic new_match();
    if (m_busy) apply_reset();
    @(negedge clk);
    cmp_en = 1'b0;
    start  = 1'b1;
    model_clear(1'b1);
    @(negedge clk);
    start = 1'b0;
    check("start_fin",   fin, 0);
    check("start_round", round, 0);
    check("start_ready", {p1_ready, p2_ready}, 3);
    cmp_en = 1'b1;
  endtask

  task automatic finish_round(input int a, input int b);
    int n = 0;
    int exp_rdy = 0;
    while (!result_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("result_valid_seen", result_valid, 1);
    model_round(a, b);
`ifdef TIE_REPLAY_EN
    if (m_result == 0) exp_rdy = 1;
`endif
    check("rv_result", result, m_result);
    check("rv_round",  round,  m_round);
    check("rv_win",    win,    m_win);
    check("rv_lose",   lose,   m_lose);
    check("rv_ready",  p1_ready, exp_rdy);
    @(negedge clk);
    check("rv_pulse", result_valid, 0);
    cmp_en = 1'b1;
  endtask

  task automatic play(input int a, input int b, input bit start_in_judge);
    @(negedge clk);
    cmp_en   = 1'b0;
    p1_valid = 1'b1; p1_move = 2'(a);
    p2_valid = 1'b1; p2_move = 2'(b);
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    check("latch_ready", {p1_ready, p2_ready}, 0);
    if (start_in_judge) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    finish_round(a, b);
  endtask

  // p2 offers 4 cycles before p1; its move changes after the first latch and
  // must be ignored.
  task automatic play_p2_early(input int a, input int b, input int b_alt);
    @(negedge clk);
    cmp_en   = 1'b0;
    p2_valid = 1'b1; p2_move = 2'(b);
    @(negedge clk);
    check("early_ready", {p1_ready, p2_ready}, 2);
    p2_move = 2'(b_alt);
    repeat (3) @(negedge clk);
    check("early_no_rv", result_valid, 0);
    p2_valid = 1'b0;
    p1_valid = 1'b1; p1_move = 2'(a);
    @(negedge clk);
    p1_valid = 1'b0;
    finish_round(a, b);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_clear(1'b0);
    repeat (2) @(negedge clk);
    check("por_counters", {round, win, lose, result, printwinner}, 0);
    check("por_flags", {fin, busy, result_valid, p1_ready, p2_ready}, 0);
    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-WAIT with p1 latched.
    new_match();
    @(negedge clk);
    cmp_en   = 1'b0;
    p1_valid = 1'b1; p1_move = PAPER;
    @(negedge clk);
    p1_valid = 1'b0;
    check("p1_latched_ready", {p1_ready, p2_ready}, 1);
    apply_reset();
    repeat (2) @(negedge clk);

    // Match A: paper beats rock three times.
    new_match();
    repeat (3) play(PAPER, ROCK, 1'b0);
    check("A_win", win, 3);
    check("A_lose", lose, 0);
    check("A_round", round, 3);
    check("A_fin", fin, 1);
    check("A_pw", printwinner, 2'b10);
    repeat (2) @(negedge clk);

    // Match B (started from DONE): rock beats scissors three times.
    new_match();
    repeat (3) play(SCISSORS, ROCK, 1'b0);
    check("B_lose", lose, 3);
    check("B_fin", fin, 1);
    check("B_pw", printwinner, 2'b11);

    // Match C: tie, p1, p2, tie, tie; start pulsed during the second JUDGE.
    new_match();
    play(ROCK, ROCK, 1'b0);
    play(PAPER, ROCK, 1'b1);
    play(ROCK, PAPER, 1'b0);
    play(SCISSORS, SCISSORS, 1'b0);
    play(PAPER, PAPER, 1'b0);
`ifdef TIE_REPLAY_EN
    check("C_round", round, 2);
    check("C_fin", fin, 0);
`else
    check("C_round", round, 5);
    check("C_win", win, 1);
    check("C_lose", lose, 1);
    check("C_fin", fin, 1);
    check("C_pw", printwinner, 2'b01);
`endif

    // Match D: illegal moves and an early p2 offer.
    new_match();
    play(ILLEGAL, ROCK, 1'b0);
    check("D_ill_result", result, 2'b11);
    check("D_ill_lose", lose, 1);
    play(ILLEGAL, ILLEGAL, 1'b0);
    check("D_both_ill_result", result, 2'b00);
    play_p2_early(ROCK, SCISSORS, PAPER);
    check("D_early_result", result, 2'b10);
    check("D_early_win", win, 1);
`ifdef TIE_REPLAY_EN
    check("D_round", round, 2);
`else
    check("D_round", round, 3);
`endif
    check("D_fin", fin, 0);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Sequencer for a two-player rock-paper-scissors match. It collects one move per player per round through a valid/ready handshake and judges each round. It keeps the round, win and lose counters from player 1's perspective and detects match end. Its round/win/lose/fin/printwinner outputs carry the same meaning and encoding the display and finish logic already consume.

Parameters:
WIN_TARGET, 3, wins needed by either player to end the match (1..15)
MAX_ROUNDS, 5, counted rounds after which the match ends regardless (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a new match; sampled only in IDLE or DONE
p1_valid  in  1  player 1 move offered
p1_move  in  2  00 rock, 01 paper, 10 scissors, 11 illegal
p1_ready  out  1  high in WAIT while no p1 move is latched
p2_valid  in  1  player 2 move offered
p2_move  in  2  same encoding as p1_move
p2_ready  out  1  high in WAIT while no p2 move is latched
busy  out  1  high in WAIT, JUDGE and CHECK
round  out  4  rounds counted so far
win  out  4  rounds won by p1
lose  out  4  rounds lost by p1 (won by p2)
result_valid  out  1  one-cycle pulse after each judged round
result  out  2  00 tie, 10 p1 round win, 11 p2 round win; held until the next judged round
fin  out  1  match finished; high only in DONE
printwinner  out  2  00 not finished, 10 p1, 11 p2, 01 draw

Behaviour:
- Reset (async, active-high): state IDLE; round, win, lose, result and printwinner all 0; fin, busy, result_valid and both ready outputs 0; latched moves cleared.
- IDLE: start=1 clears all counters, result and printwinner, then moves to WAIT.
- WAIT: a move is latched when p?_valid && p?_ready. Both players may be latched in the same cycle. Valid while ready=0 is ignored. When both moves are latched, go to JUDGE on the next edge.
- JUDGE (1 cycle):
  - Paper beats rock, scissors beats paper, rock beats scissors. Equal legal moves are a tie.
  - One illegal move: the other player wins the round. Both illegal: tie.
  - Increment round. Increment win or lose for a decided round.
  - Register result; pulse result_valid in the following cycle. Clear the latched moves. Go to CHECK.
- CHECK (1 cycle), priority order:
  1. win==WIN_TARGET: printwinner=10.
  2. lose==WIN_TARGET: printwinner=11.
  3. round==MAX_ROUNDS: printwinner=10 if win>lose, 11 if lose>win, else 01.
  - Any of these goes to DONE with fin=1. Otherwise return to WAIT.
- DONE: fin=1 and printwinner held; counters frozen. start=1 behaves as in IDLE, clearing fin and printwinner in the same edge.
- Latency: at least 3 cycles from the second move latch to the next ready.
- start is ignored while busy.
- Counters never exceed 15 because both parameters are ≤15; no wrap is reachable.
- Reset asserted mid-round discards all latched moves.

Optional Feature:
TIE_REPLAY_EN
- Defined: a tied round does not increment round. result_valid still pulses with result=00, and CHECK is skipped (JUDGE goes directly to WAIT).
- Undefined: a tie counts as a round as described above.

Decomposition:
- Package game_pkg: move encodings (ROCK, PAPER, SCISSORS, ILLEGAL); result codes (TIE, P1_WIN, P2_WIN); printwinner codes (NONE, DRAW, P1, P2); state enum (IDLE, WAIT, JUDGE, CHECK, DONE).
- Sub-module rps_judge: combinational, two 2-bit moves in, 2-bit result out. Reusable by the finish logic.

Test Plan (WIN_TARGET=3, MAX_ROUNDS=5):
- Reset mid-WAIT with p1 latched -> all outputs 0, state IDLE, p1_ready=0; start then gives p1_ready=p2_ready=1.
- p1 always paper vs p2 rock, 3 rounds -> win=3, lose=0, round=3, fin=1, printwinner=10.
- p1 scissors vs p2 rock, 3 rounds -> lose=3, fin=1, printwinner=11.
- Rounds: tie, p1, p2, tie, tie (5 rounds) -> round=5, win=1, lose=1, printwinner=01. With TIE_REPLAY_EN the same stimulus gives round=2, fin=0.
- p1_move=11 vs p2 rock -> result=11, lose increments. Both 11 -> result=00. p2 valid 4 cycles before p1 -> single latch, one round counted.
- start pulsed in JUDGE -> ignored. start in DONE -> counters reset, fin=0 the next cycle, new match proceeds.
